// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction buffer between fetch and decode. Circular buffer
//                that accepts up to FETCH_W instructions per cycle (compacted,
//                in slot order) and presents the FETCH_W oldest entries to
//                decode in program order. A flush empties it in one cycle.
//  Ports       : clk, reset       - clock, asynchronous active-high reset
//                if_valid/pc/instr - fetch group (per-slot valid)
//                fq_stall         - queue cannot take a full fetch group
//                flush            - discard all contents
//                id_valid/pc/instr - oldest entries toward decode
//                id_ready         - decode consumes all presented entries
//                fq_count         - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [FETCH_W-1:0]                if_valid,
    input  logic [FETCH_W-1:0][PC_W-1:0]      if_pc,
    input  logic [FETCH_W-1:0][INSTR_W-1:0]   if_instr,
    output logic                              fq_stall,
    input  logic                              flush,
    output logic [FETCH_W-1:0]                id_valid,
    output logic [FETCH_W-1:0][PC_W-1:0]      id_pc,
    output logic [FETCH_W-1:0][INSTR_W-1:0]   id_instr,
    input  logic                              id_ready,
    output logic [$clog2(DEPTH):0]            fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_fetch_cnt = CNT_W'(FETCH_W);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_enq_ok;
    logic [PTR_W-1:0]   w_acc;
    logic [PTR_W-1:0]   w_wr_idx [FETCH_W];
    logic [CNT_W-1:0]   w_n_enq;
    logic [CNT_W-1:0]   w_n_deq;

    // Stall depends only on the registered count, never on live inputs.
    assign fq_stall = (c_depth_cnt - r_count) < c_fetch_cnt;
    assign fq_count = r_count;
    assign w_enq_ok = !fq_stall && !flush;

    // Compaction: each valid slot lands at tail + (number of valid slots
    // below it), so invalid slots leave no hole.
    always_comb begin
        w_acc   = '0;
        w_n_enq = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_wr_idx[i] = r_tail + w_acc;
            if (if_valid[i]) begin
                w_acc = w_acc + PTR_W'(1);
            end
        end
        if (w_enq_ok) begin
            w_n_enq = {1'b0, w_acc};
        end
    end

    // Presented entries are always contiguous from slot 0, so consuming them
    // all is a popcount of id_valid.
    always_comb begin
        w_n_deq = '0;
        if (id_ready && !flush) begin
            for (int i = 0; i < FETCH_W; i++) begin
                w_n_deq = w_n_deq + CNT_W'(id_valid[i]);
            end
        end
    end

    generate
        for (genvar g = 0; g < FETCH_W; g++) begin : g_present
            logic [PTR_W-1:0] w_rd_idx;
            assign w_rd_idx    = r_head + PTR_W'(g);
            assign id_valid[g] = r_count > CNT_W'(g);
            assign id_pc[g]    = r_pc_mem[w_rd_idx];
            assign id_instr[g] = r_instr_mem[w_rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_pc_mem[k]    <= '0;
                r_instr_mem[k] <= '0;
            end
        end else if (flush) begin
            // Storage is left as is; only the bookkeeping is cleared.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_ok) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (if_valid[i]) begin
                        r_pc_mem[w_wr_idx[i]]    <= if_pc[i];
                        r_instr_mem[w_wr_idx[i]] <= if_instr[i];
                    end
                end
            end
            r_tail  <= r_tail + w_n_enq[PTR_W-1:0];
            r_head  <= r_head + w_n_deq[PTR_W-1:0];
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue (FETCH_W=2, DEPTH=8).
//                Directed scenarios followed by random traffic, compared
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic              clk;
    logic              reset;
    logic [1:0]        if_valid;
    logic [1:0][31:0]  if_pc;
    logic [1:0][31:0]  if_instr;
    logic              fq_stall;
    logic              flush;
    logic [1:0]        id_valid;
    logic [1:0][31:0]  id_pc;
    logic [1:0][31:0]  id_instr;
    logic              id_ready;
    logic [3:0]        fq_count;

    fetch_queue #(.FETCH_W(2), .DEPTH(8), .PC_W(32), .INSTR_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .fq_stall (fq_stall),
        .flush    (flush),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_ready (id_ready),
        .fq_count (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] pc_next = 32'h100;
    logic [63:0] mq[$];   // reference contents, oldest first: {pc, instr}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0] ev;
        for (int i = 0; i < 2; i++) ev[i] = (mq.size() > i);
        chk("fq_count", 64'(fq_count), 64'(mq.size()));
        chk("fq_stall", 64'(fq_stall), 64'((8 - mq.size()) < 2));
        chk("id_valid", 64'(id_valid), 64'(ev));
        for (int i = 0; i < 2; i++)
            if (mq.size() > i) chk("id_slot", {id_pc[i], id_instr[i]}, mq[i]);
    endtask

    // Advance the reference model with the current inputs, clock, then compare.
    task automatic do_cycle();
        int  n_deq;
        bit  stall_m;
        stall_m = (8 - mq.size()) < 2;
        if (flush) mq.delete();
        else begin
            n_deq = id_ready ? ((mq.size() < 2) ? mq.size() : 2) : 0;
            repeat (n_deq) void'(mq.pop_front());
            if (!stall_m)
                for (int i = 0; i < 2; i++)
                    if (if_valid[i]) mq.push_back({if_pc[i], if_instr[i]});
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Fresh fetch group with ascending PCs for the valid slots.
    task automatic set_group(input logic [1:0] v);
        if_valid = v;
        for (int i = 0; i < 2; i++) begin
            if_pc[i]    = v[i] ? pc_next : 32'hDEAD_0000;
            if_instr[i] = $urandom;
            if (v[i]) pc_next = pc_next + 32'd4;
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
        if_valid = '0; if_pc = '0; if_instr = '0;
        #1;
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_stall", 64'(fq_stall), 64'd0);
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_pc",    id_pc,    64'd0);
        chk("rst_instr", id_instr, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Fill with the same two-instruction group four times.
        if_valid = 2'b11;
        if_pc    = {32'h4, 32'h0};
        if_instr = {32'h22222222, 32'h11111111};
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            chk("fill_count", 64'(fq_count), 64'(2 * (k + 1)));
        end
        chk("fill_stall", 64'(fq_stall), 64'd1);
        chk("fill_pc", id_pc, {32'h4, 32'h0});

        // Stalled: groups are ignored.
        for (int k = 0; k < 3; k++) begin
            set_group(2'b11);
            do_cycle();
            chk("stall_count", 64'(fq_count), 64'd8);
        end
        if_valid = 2'b00; id_ready = 1'b1;
        do_cycle();
        chk("drain_count", 64'(fq_count), 64'd6);
        chk("drain_stall", 64'(fq_stall), 64'd0);

        // Compaction from empty.
        id_ready = 1'b0; flush = 1'b1;
        do_cycle();
        flush = 1'b0;
        if_valid = 2'b10; if_pc = {32'h8, 32'hFFFF_FFF0}; if_instr = {32'h33333333, 32'h0};
        do_cycle();
        chk("cmp_valid", 64'(id_valid), 64'd1);
        chk("cmp_pc",    64'(id_pc[0]), 64'h8);
        chk("cmp_instr", 64'(id_instr[0]), 64'h33333333);

        // Concurrent traffic at count 1, wrapping the pointers.
        flush = 1'b1; if_valid = 2'b00;
        do_cycle();
        flush = 1'b0;
        set_group(2'b01);
        do_cycle();
        id_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_group(2'b11);
            do_cycle();
            chk("conc_count", 64'(fq_count), 64'd2);
        end

        // Flush at count 5 with live fetch and decode.
        id_ready = 1'b0; flush = 1'b1; if_valid = 2'b00;
        do_cycle();
        flush = 1'b0;
        set_group(2'b11); do_cycle();
        set_group(2'b11); do_cycle();
        set_group(2'b01); do_cycle();
        chk("pre_flush_count", 64'(fq_count), 64'd5);
        flush = 1'b1; id_ready = 1'b1; set_group(2'b11);
        do_cycle();
        chk("flush_count", 64'(fq_count), 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);
        flush = 1'b0; id_ready = 1'b0;
        if_valid = 2'b01; if_pc = {32'h0, 32'h8}; if_instr = {32'h0, 32'h44444444};
        do_cycle();
        chk("post_flush_pc", 64'(id_pc[0]), 64'h8);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            set_group(2'($urandom_range(0, 3)));
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            do_cycle();
        end

        // Asynchronous reset between edges at count 4.
        flush = 1'b1; id_ready = 1'b0; if_valid = 2'b00;
        do_cycle();
        flush = 1'b0;
        set_group(2'b11); do_cycle();
        set_group(2'b11); do_cycle();
        chk("pre_rst_count", 64'(fq_count), 64'd4);
        if_valid = 2'b00;
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 64'(fq_count), 64'd0);
        chk("arst_valid", 64'(id_valid), 64'd0);
        chk("arst_stall", 64'(fq_stall), 64'd0);
        chk("arst_pc",    id_pc,    64'd0);
        chk("arst_instr", id_instr, 64'd0);
        mq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        set_group(2'b11);
        do_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
